wb_dds_regs: RTL

WB_DDS_REGS -- requirements
Module: wb_dds_regs

---
 rtl/wb_dds_regs.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_dds_regs.sv
// Wishbone classic slave holding per-channel DDS control registers and a
// write-only wave-memory window; every transfer is a fixed IDLE->RESP pair.
module wb_dds_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 4,
    parameter int MEM_AW     = 6,
    parameter int WAVE_WIDTH = 16,
    localparam int CHW       = $clog2(NUM_CH)
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic                         wb_lock_i,
    input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [NUM_CH-1:0]            ch_enable_o,
    output logic [2*NUM_CH-1:0]          ch_wave_sel_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_phase_inc_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_phase_ofs_o,
    output logic [NUM_CH-1:0]            ch_sync_o,
    output logic                         mem_wr_en_o,
    output logic [CHW-1:0]               mem_wr_ch_o,
    output logic [MEM_AW-1:0]            mem_wr_addr_o,
    output logic [WAVE_WIDTH-1:0]        mem_wr_dat_o
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]       en_q, en_d;
    logic [1:0]              wave_q [NUM_CH];
    logic [1:0]              wave_d [NUM_CH];
    logic [DATA_WIDTH-1:0]   inc_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   inc_d [NUM_CH];
    logic [DATA_WIDTH-1:0]   ofs_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   ofs_d [NUM_CH];
    logic [NUM_CH-1:0]       seen_q, seen_d, seen_set, seen_clr;
    logic [NUM_CH-1:0]       sync_q, sync_d;
    logic                    mem_en_q, mem_en_d;
    logic [CHW-1:0]          mem_ch_q, mem_ch_d;
    logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
    logic [WAVE_WIDTH-1:0]   mem_dat_q, mem_dat_d;

    logic                    req, is_mem, unmapped;
    logic [CHW-1:0]          reg_ch, mem_ch;
    logic [1:0]              reg_sel;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    unused_lock;

    assign unused_lock = wb_lock_i;
    assign req         = wb_cyc_i & wb_stb_i;

    // Any set bit between the decoded field and the space-select MSB is unmapped.
    always_comb begin
        is_mem   = wb_addr_i[ADDR_WIDTH-1];
        reg_ch   = wb_addr_i[CHW+1:2];
        reg_sel  = wb_addr_i[1:0];
        mem_ch   = wb_addr_i[MEM_AW+CHW-1:MEM_AW];
        mem_idx  = wb_addr_i[MEM_AW-1:0];
        unmapped = 1'b0;
        for (int i = 0; i < ADDR_WIDTH-1; i++) begin
            if (is_mem ? (i >= MEM_AW+CHW) : (i >= CHW+2)) begin
                unmapped = unmapped | wb_addr_i[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        sync_d     = '0;
        en_d       = en_q;
        wave_d     = wave_q;
        inc_d      = inc_q;
        ofs_d      = ofs_q;
        seen_set   = '0;
        seen_clr   = '0;
        mem_en_d   = 1'b0;
        mem_ch_d   = mem_ch_q;
        mem_addr_d = mem_addr_q;
        mem_dat_d  = mem_dat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_RESP;
                    if (unmapped || (!is_mem && reg_sel == 2'd3 && wb_we_i)) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (is_mem) begin
                            if (wb_we_i) begin
                                mem_en_d   = 1'b1;
                                mem_ch_d   = mem_ch;
                                mem_addr_d = mem_idx;
                                mem_dat_d  = wb_dat_i[WAVE_WIDTH-1:0];
                            end
                        end else if (wb_we_i) begin
                            case (reg_sel)
                                2'd0: begin
                                    if (wb_sel_i[0]) begin
                                        en_d[reg_ch]   = wb_dat_i[0];
                                        wave_d[reg_ch] = wb_dat_i[2:1];
                                        if (wb_dat_i[4]) begin
                                            sync_d[reg_ch]   = 1'b1;
                                            seen_set[reg_ch] = 1'b1;
                                        end
                                    end
                                end
                                2'd1: begin
                                    for (int b = 0; b < SW; b++) begin
                                        if (wb_sel_i[b]) inc_d[reg_ch][8*b +: 8] = wb_dat_i[8*b +: 8];
                                    end
                                end
                                2'd2: begin
                                    for (int b = 0; b < SW; b++) begin
                                        if (wb_sel_i[b]) ofs_d[reg_ch][8*b +: 8] = wb_dat_i[8*b +: 8];
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            case (reg_sel)
                                2'd0: begin
                                    rdata_d[0]   = en_q[reg_ch];
                                    rdata_d[2:1] = wave_q[reg_ch];
                                end
                                2'd1: rdata_d = inc_q[reg_ch];
                                2'd2: rdata_d = ofs_q[reg_ch];
                                default: begin
                                    rdata_d[0]       = en_q[reg_ch];
                                    rdata_d[1]       = seen_q[reg_ch];
                                    seen_clr[reg_ch] = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A sync set in the same cycle outranks the clear-on-read.
        seen_d = (seen_q & ~seen_clr) | seen_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            en_q       <= '0;
            seen_q     <= '0;
            sync_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_ch_q   <= '0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wave_q[i] <= '0;
                inc_q[i]  <= '0;
                ofs_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            seen_q     <= seen_d;
            sync_q     <= sync_d;
            mem_en_q   <= mem_en_d;
            mem_ch_q   <= mem_ch_d;
            mem_addr_q <= mem_addr_d;
            mem_dat_q  <= mem_dat_d;
            wave_q     <= wave_d;
            inc_q      <= inc_d;
            ofs_q      <= ofs_d;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign wb_dat_o      = rdata_q;
    assign ch_enable_o   = en_q;
    assign ch_sync_o     = sync_q;
    assign mem_wr_en_o   = mem_en_q;
    assign mem_wr_ch_o   = mem_ch_q;
    assign mem_wr_addr_o = mem_addr_q;
    assign mem_wr_dat_o  = mem_dat_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ch_wave_sel_o[2*g +: 2]                = wave_q[g];
        assign ch_phase_inc_o[g*DATA_WIDTH +: DATA_WIDTH] = inc_q[g];
        assign ch_phase_ofs_o[g*DATA_WIDTH +: DATA_WIDTH] = ofs_q[g];
    end

endmodule
